// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its companion detector.
package seq_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;
    localparam int            DEFAULT_PAT_W   = 4;
    localparam logic [3:0]    DEFAULT_PATTERN = 4'b1110;
endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/stream bundle between a controller (master) and the pattern generator (slave).
interface seq_pattern_gen_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic [CNT_W-1:0] rpt_i;
    logic [3:0]       gap_i;
    logic             bit_ready_i;
    logic             bit_o;
    logic             bit_valid_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start, rpt_i, gap_i, bit_ready_i,
        input  bit_o, bit_valid_o, busy_o, done_o
    );

    modport slave (
        input  start, rpt_i, gap_i, bit_ready_i,
        output bit_o, bit_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/seq_piso.sv
// Parallel-in serial-out shift register, MSB first; load wins over shift.
module seq_piso #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] par_i,
    output logic         ser_o
);
    logic [W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load)       sr_d = par_i;
        else if (shift) sr_d = sr_q << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign ser_o = sr_q[W-1];
endmodule

// File: rtl/seq_pattern_gen.sv
// Emits PATTERN serially rpt times with gap zero-bits between repetitions,
// under a valid/ready handshake, then pulses done.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int             PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_pattern_gen_if.slave bus
);
    localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(PAT_W - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic [3:0]       gap_q, gap_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             load, shift, ser;

    seq_piso #(.W(PAT_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .par_i (PATTERN),
        .ser_o (ser)
    );

    always_comb begin
        state_d   = state_q;
        rpt_d     = rpt_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        bit_cnt_d = bit_cnt_q;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rpt_d     = bus.rpt_i;
                    gap_d     = bus.gap_i;
                    bit_cnt_d = LAST_IDX;
                    load      = 1'b1;
                    state_d   = (bus.rpt_i == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (bus.bit_ready_i) begin
                    if (bit_cnt_q == '0) begin
                        // Testing the pre-decrement value keeps rpt = all-ones from wrapping.
                        rpt_d = rpt_q - 1'b1;
                        if (rpt_q == CNT_W'(1)) begin
                            state_d = DONE;
                        end else if (gap_q == 4'd0) begin
                            load      = 1'b1;
                            bit_cnt_d = LAST_IDX;
                        end else begin
                            gap_cnt_d = gap_q;
                            state_d   = GAP;
                        end
                    end else begin
                        shift     = 1'b1;
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
            end
            GAP: begin
                if (bus.bit_ready_i) begin
                    if (gap_cnt_q == 4'd1) begin
                        load      = 1'b1;
                        bit_cnt_d = LAST_IDX;
                        state_d   = SEND;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 4'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rpt_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_q     <= rpt_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs decode the registered state only, so they cannot move while ready is low.
    assign bus.bit_valid_o = (state_q == SEND) || (state_q == GAP);
    assign bus.bit_o       = (state_q == SEND) && ser;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = (state_q == DONE);
endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits.
REQ-002 Parameter PATTERN, default 4'b1110: serial pattern to emit, MSB first.
REQ-003 Parameter CNT_W, default 8: width of the repeat count.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request pulse; sampled only in IDLE.
REQ-007 rpt_i  input  CNT_W  number of pattern repetitions, captured with start.
REQ-008 gap_i  input  4  number of 0-bits inserted between repetitions, captured with start.
REQ-009 bit_ready_i  input  1  downstream accepts bit_o this cycle.
REQ-010 bit_o  output  1  serial data bit.
REQ-011 bit_valid_o  output  1  bit_o is valid.
REQ-012 busy_o  output  1  high from the cycle after accepted start until the cycle done_o is asserted, inclusive.
REQ-013 done_o  output  1  single-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, GAP and DONE.
REQ-015 In IDLE with start=1, the block SHALL capture rpt_i and gap_i and load PATTERN into the shift register.
- rpt_i=0: next state DONE.
- Otherwise: next state SEND.
REQ-016 A bit SHALL transfer only in a cycle with bit_valid_o=1 and bit_ready_i=1.
- While bit_ready_i=0, bit_o and bit_valid_o SHALL hold unchanged.
REQ-017 In SEND:
- bit_valid_o=1 and bit_o = current pattern bit, MSB first.
- Each transfer advances one bit.
- After transfer of bit 0, the repetition counter SHALL decrement.
REQ-018 After the last bit of a repetition:
- Counter reaches 0: next state DONE.
- Counter nonzero and captured gap = 0: next state SEND with the pattern reloaded; no idle cycle.
- Counter nonzero and captured gap > 0: next state GAP.
REQ-019 In GAP:
- bit_valid_o=1 and bit_o=0.
- Exactly the captured gap count of 0-bits SHALL transfer, then next state SEND with the pattern reloaded.
REQ-020 No gap bits SHALL be emitted after the final repetition.
REQ-021 In DONE:
- done_o=1 and bit_valid_o=0 for exactly one cycle.
- Next state IDLE.
REQ-022 start SHALL be ignored in every state other than IDLE, including the DONE cycle.
REQ-023 Latency: with start accepted at cycle N, the first bit SHALL be valid at cycle N+1.
REQ-024 With bit_ready_i held high, one repetition SHALL take PAT_W cycles and one gap SHALL take gap cycles.
- Total SEND+GAP cycles = rpt*PAT_W + (rpt-1)*gap.
REQ-025 Counter arithmetic is unsigned, CNT_W bits; rpt_i = 2^CNT_W - 1 SHALL be fully supported with no wrap.
REQ-026 In IDLE and DONE, bit_o SHALL be 0.

Reset
REQ-027 When rst=1 at a clock edge, the next state SHALL be IDLE and all outputs SHALL be 0.
- Outputs: bit_o, bit_valid_o, busy_o, done_o.
REQ-028 Reset SHALL take priority over start and abort any transfer in progress.
- No done_o pulse is generated for an aborted run.
REQ-029 The counters and shift register SHALL be cleared to 0 on reset.

Structure
REQ-030 A shared package seq_pkg SHALL hold:
- the state enumeration (IDLE, SEND, GAP, DONE);
- the default PATTERN constant 4'b1110, also used by the detector block.
REQ-031 The parallel-in serial-out shift register SHALL be the sub-module seq_piso.
- Ports: load, shift, parallel-in, serial-out.
- The FSM and counters remain in seq_pattern_gen.

Verification
REQ-032 rst for 2 cycles mid-run (during bit 2 of repetition 1) -> all outputs 0 next cycle; no done_o; a later start runs normally.
REQ-033 start with rpt_i=1, gap_i=0, bit_ready_i=1 -> bit_o 1,1,1,0 on cycles N+1..N+4; done_o at N+5; busy_o high for N+1..N+5.
REQ-034 start with rpt_i=2, gap_i=3, bit_ready_i=1 -> stream 1110 000 1110, 11 valid cycles, then one done_o pulse.
REQ-035 start with rpt_i=3, gap_i=0, bit_ready_i toggling 1,0 each cycle -> 12 transfers of 111011101110; bit_o stable in every stalled cycle.
REQ-036 start with rpt_i=0 -> done_o at N+1, bit_valid_o never asserted.
REQ-037 start pulsed while busy_o=1 and in the DONE cycle -> ignored; repetition count and bit stream unchanged.
